// File: rtl/ptmch_trig_gen_if.sv
// ptmch_trig_gen_if: SPI host link and trigger outputs of ptmch_trig_gen
//   SPI_CS/SPI_CLK/SPI_MOSI : host -> generator, asynchronous SPI mode 0
//   TRG_IN                  : host -> generator, external trigger (PTMCH_EXT_TRG_EN only)
//   TRG_PLS[CH_N]           : generator -> host, per-channel pulse outputs
interface ptmch_trig_gen_if #(parameter int CH_N = 5);
  logic SPI_CS;
  logic SPI_CLK;
  logic SPI_MOSI;
  logic [CH_N-1:0] TRG_PLS;
`ifdef PTMCH_EXT_TRG_EN
  logic TRG_IN;
  modport master (output SPI_CS, SPI_CLK, SPI_MOSI, TRG_IN, input TRG_PLS);
  modport slave (input SPI_CS, SPI_CLK, SPI_MOSI, TRG_IN, output TRG_PLS);
`else
  modport master (output SPI_CS, SPI_CLK, SPI_MOSI, input TRG_PLS);
  modport slave (input SPI_CS, SPI_CLK, SPI_MOSI, output TRG_PLS);
`endif
endinterface

// File: rtl/ptmch_trig_gen.sv
// ptmch_trig_gen: SPI-programmable multi-channel trigger pulse generator
//   CLK160M : system clock
//   RESET_N : asynchronous active-low reset, release synchronised to CLK160M
//   bus     : ptmch_trig_gen_if slave (SPI inputs, TRG_IN, TRG_PLS outputs)
//   Optional macro PTMCH_EXT_TRG_EN adds TRG_IN and the ARM (0x7) opcode.
module ptmch_trig_gen #(
  parameter int CH_N = 5,
  parameter int CNT_W = 16
) (
  input logic CLK160M,
  input logic RESET_N,
  ptmch_trig_gen_if.slave bus
);
  localparam int PW = CNT_W + 1;
  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_HIGH, S_LOW} st_e;
  logic [1:0] r_rst_s;
  logic w_rst_n;
  always_ff @(posedge CLK160M or negedge RESET_N)
    if (!RESET_N) r_rst_s <= '0;
    else r_rst_s <= {r_rst_s[0], 1'b1};
  assign w_rst_n = r_rst_s[1];
  logic [1:0] r_cs_s, r_sck_s, r_mosi_s;
  logic r_cs_d, r_sck_d, r_commit;
  logic [5:0] r_bits;
  logic [31:0] r_sh;
  // Bit count saturates at 33 so over-long frames stay distinguishable from 32.
  always_ff @(posedge CLK160M or negedge w_rst_n)
    if (!w_rst_n) begin
      r_cs_s <= 2'b11;
      r_sck_s <= '0;
      r_mosi_s <= '0;
      r_cs_d <= 1'b1;
      r_sck_d <= 1'b0;
      r_bits <= '0;
      r_sh <= '0;
      r_commit <= 1'b0;
    end else begin
      r_cs_s <= {r_cs_s[0], bus.SPI_CS};
      r_sck_s <= {r_sck_s[0], bus.SPI_CLK};
      r_mosi_s <= {r_mosi_s[0], bus.SPI_MOSI};
      r_cs_d <= r_cs_s[1];
      r_sck_d <= r_sck_s[1];
      r_commit <= r_cs_s[1] & ~r_cs_d & (r_bits == 6'd32);
      if (r_cs_s[1] & r_cs_d) r_bits <= '0;
      else if (!r_cs_s[1] & r_sck_s[1] & ~r_sck_d) begin
        r_sh <= {r_sh[30:0], r_mosi_s[1]};
        r_bits <= (r_bits == 6'd33) ? r_bits : r_bits + 6'd1;
      end
    end
  logic [3:0] w_op, w_ch;
  logic [CNT_W-1:0] w_val;
  logic [CH_N-1:0] w_mask, w_fire, w_abort, w_pls;
  assign w_op = r_sh[31:28];
  assign w_ch = r_sh[27:24];
  assign w_val = r_sh[CNT_W-1:0];
  assign w_mask = r_sh[CH_N-1:0];
  assign w_abort = (r_commit && w_op == 4'h6) ? w_mask : '0;
`ifdef PTMCH_EXT_TRG_EN
  logic [2:0] r_trg_s;
  logic [CH_N-1:0] r_arm;
  always_ff @(posedge CLK160M or negedge w_rst_n)
    if (!w_rst_n) begin
      r_trg_s <= '0;
      r_arm <= '0;
    end else begin
      r_trg_s <= {r_trg_s[1:0], bus.TRG_IN};
      if (r_commit && w_op == 4'h7) r_arm <= w_mask;
    end
  assign w_fire = ((r_commit && w_op == 4'h5) ? w_mask : '0) | ((r_trg_s[1] & ~r_trg_s[2]) ? r_arm : '0);
`else
  assign w_fire = (r_commit && w_op == 4'h5) ? w_mask : '0;
`endif
  for (genvar c = 0; c < CH_N; c++) begin : g_ch
    st_e r_st, w_st;
    logic [CNT_W-1:0] r_dly, r_wid, r_per, r_cnt, r_tc, w_tc, r_rem, w_rem, r_hl, r_ll, w_wt;
    logic [CNT_W:0] w_pe;
    logic r_z, r_pls, w_sel;
    assign w_sel = r_commit && w_ch == 4'(c);
    // Zero width still spends one (silent) high slot so the train keeps its timing.
    always_comb begin
      w_wt = (r_wid == '0) ? CNT_W'(1) : r_wid;
      w_pe = (r_per > w_wt) ? {1'b0, r_per} : {1'b0, w_wt} + PW'(1);
      w_st = r_st;
      w_tc = r_tc;
      w_rem = r_rem;
      if (w_abort[c]) w_st = S_IDLE;
      else
        unique case (r_st)
          S_IDLE:
            if (w_fire[c]) begin
              w_st = S_DELAY;
              w_tc = r_dly;
              w_rem = (r_cnt == '0) ? CNT_W'(1) : r_cnt;
            end
          S_HIGH:
            if (r_tc == '0) begin
              w_st = (r_rem > CNT_W'(1)) ? S_LOW : S_IDLE;
              w_tc = r_ll;
              w_rem = r_rem - CNT_W'(1);
            end else w_tc = r_tc - CNT_W'(1);
          default: begin
            w_st = (r_tc == '0) ? S_HIGH : r_st;
            w_tc = (r_tc == '0) ? r_hl : r_tc - CNT_W'(1);
          end
        endcase
    end
    always_ff @(posedge CLK160M or negedge w_rst_n)
      if (!w_rst_n) begin
        r_dly <= '0;
        r_wid <= '0;
        r_per <= '0;
        r_cnt <= '0;
        r_st <= S_IDLE;
        r_tc <= '0;
        r_rem <= '0;
        r_hl <= '0;
        r_ll <= '0;
        r_z <= 1'b0;
        r_pls <= 1'b0;
      end else begin
        if (w_sel && w_op == 4'h1) r_dly <= w_val;
        if (w_sel && w_op == 4'h2) r_wid <= w_val;
        if (w_sel && w_op == 4'h3) r_per <= w_val;
        if (w_sel && w_op == 4'h4) r_cnt <= w_val;
        // Snapshot the pulse shape at fire; later writes only affect the next fire.
        if (r_st == S_IDLE && w_fire[c]) begin
          r_hl <= w_wt - CNT_W'(1);
          r_ll <= CNT_W'(w_pe - {1'b0, w_wt} - PW'(1));
          r_z <= r_wid == '0;
        end
        r_st <= w_st;
        r_tc <= w_tc;
        r_rem <= w_rem;
        r_pls <= (w_st == S_HIGH) && !r_z;
      end
    assign w_pls[c] = r_pls;
  end
  assign bus.TRG_PLS = w_pls;
endmodule

// File: tb/tb_ptmch_trig_gen.sv
// tb_ptmch_trig_gen: scoreboard bench for ptmch_trig_gen pulse trains
module tb_ptmch_trig_gen;
  localparam int CH_N = 5;
  localparam int CNT_W = 16;
  typedef struct {
    int cyc;
    logic [CH_N-1:0] val;
  } ev_t;
  logic CLK160M = 1'b0;
  logic RESET_N = 1'b1;
  int cyc = 0;
  int nt = 0;
  int nf = 0;
  int t;
  ev_t exp_q[$];
  ev_t e;
  logic [CH_N-1:0] prev = '0;
  ptmch_trig_gen_if #(.CH_N(CH_N)) bus ();
  ptmch_trig_gen #(.CH_N(CH_N), .CNT_W(CNT_W)) dut (.CLK160M(CLK160M), .RESET_N(RESET_N), .bus(bus));
  always #5 CLK160M = ~CLK160M;
  always @(posedge CLK160M) cyc <= cyc + 1;
  always @(negedge CLK160M)
    if (bus.TRG_PLS != prev) begin
      prev = bus.TRG_PLS;
      nt++;
      if (exp_q.size() == 0) begin
        nf++;
        $display("FAIL unexpected_edge: got %h at cycle %0d, required no change", prev, cyc);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.val != prev) begin
          nf++;
          $display("FAIL pls_edge: got %h at cycle %0d, required %h at cycle %0d", prev, cyc, e.val, e.cyc);
        end
      end
    end
  task automatic chk(input string n, input int act, input int req);
    nt++;
    if (act != req) begin
      nf++;
      $display("FAIL %s: got %0d, required %0d", n, act, req);
    end
  endtask
  task automatic push(input int c, input int v);
    exp_q.push_back('{c, CH_N'(v)});
  endtask
  task automatic spi(input logic [32:0] f, input int n, output int tc);
    int c0;
    c0 = cyc;
    bus.SPI_CS = 1'b0;
    for (int i = n - 1; i >= 0; i--) begin
      bus.SPI_MOSI = f[i];
      repeat (4) @(negedge CLK160M);
      bus.SPI_CLK = 1'b1;
      repeat (4) @(negedge CLK160M);
      bus.SPI_CLK = 1'b0;
    end
    repeat (4) @(negedge CLK160M);
    bus.SPI_CS = 1'b1;
    tc = c0 + 8 * n + 7;
    repeat (4) @(negedge CLK160M);
  endtask
  task automatic wr(input logic [3:0] op, input logic [3:0] ch, input logic [23:0] v);
    int tc;
    spi({1'b0, op, ch, v}, 32, tc);
  endtask
  initial begin
    bus.SPI_CS = 1'b1;
    bus.SPI_CLK = 1'b0;
    bus.SPI_MOSI = 1'b0;
`ifdef PTMCH_EXT_TRG_EN
    bus.TRG_IN = 1'b0;
`endif
    #1 RESET_N = 1'b0;
    repeat (3) @(negedge CLK160M);
    chk("reset_pls", int'(bus.TRG_PLS), 0);
    RESET_N = 1'b1;
    repeat (4) @(negedge CLK160M);
    // ch2: single delayed pulse
    wr(4'h1, 4'd2, 24'd10);
    wr(4'h2, 4'd2, 24'd4);
    wr(4'h4, 4'd2, 24'd1);
    t = cyc + 263;
    push(t + 12, 5'h04);
    push(t + 16, 5'h00);
    wr(4'h5, 4'd0, 24'h04);
    repeat (30) @(negedge CLK160M);
    // ch0 + ch4: aligned 3-pulse trains
    wr(4'h2, 4'd0, 24'd3);
    wr(4'h3, 4'd0, 24'd8);
    wr(4'h4, 4'd0, 24'd3);
    wr(4'h2, 4'd4, 24'd3);
    wr(4'h3, 4'd4, 24'd8);
    wr(4'h4, 4'd4, 24'd3);
    t = cyc + 263;
    for (int k = 0; k < 3; k++) begin
      push(t + 2 + 8 * k, 5'h11);
      push(t + 5 + 8 * k, 5'h00);
    end
    wr(4'h5, 4'd0, 24'h11);
    repeat (30) @(negedge CLK160M);
    // short/long frames and out-of-range channel write are all discarded
    spi({1'b0, 32'h5000001F}, 31, t);
    spi({32'h5000001F, 1'b0}, 33, t);
    wr(4'h2, 4'd9, 24'd7);
    wr(4'h5, 4'd0, 24'h02);
    repeat (20) @(negedge CLK160M);
    // ch1: period clamps to width+1, re-fire ignored, abort mid-pulse
    wr(4'h2, 4'd1, 24'd5);
    wr(4'h3, 4'd1, 24'd2);
    wr(4'h4, 4'd1, 24'd100);
    t = cyc + 263;
    for (int k = 0; k <= 88; k++) begin
      push(t + 2 + 6 * k, 5'h02);
      push((k == 88) ? t + 532 : t + 7 + 6 * k, 5'h00);
    end
    wr(4'h5, 4'd0, 24'h02);
    wr(4'h5, 4'd0, 24'h02);
    repeat (3) @(negedge CLK160M);
    wr(4'h6, 4'd0, 24'h02);
    repeat (20) @(negedge CLK160M);
    // reset during a high pulse
    wr(4'h2, 4'd3, 24'd20);
    t = cyc + 263;
    push(t + 2, 5'h08);
    push(t + 5, 5'h00);
    wr(4'h5, 4'd0, 24'h08);
    while (cyc < t + 5) begin
      @(posedge CLK160M);
      #1;
    end
    RESET_N = 1'b0;
    #1 chk("rst_async_pls", int'(bus.TRG_PLS), 0);
    repeat (4) @(negedge CLK160M);
    RESET_N = 1'b1;
    repeat (4) @(negedge CLK160M);
    wr(4'h5, 4'd0, 24'h01);
    repeat (20) @(negedge CLK160M);
    wr(4'h2, 4'd0, 24'd2);
    t = cyc + 263;
    push(t + 2, 5'h01);
    push(t + 4, 5'h00);
    wr(4'h5, 4'd0, 24'h01);
    repeat (20) @(negedge CLK160M);
`ifdef PTMCH_EXT_TRG_EN
    wr(4'h2, 4'd1, 24'd2);
    wr(4'h2, 4'd3, 24'd2);
    wr(4'h7, 4'd0, 24'h0A);
    push(cyc + 4, 5'h0A);
    push(cyc + 6, 5'h00);
    bus.TRG_IN = 1'b1;
    repeat (4) @(negedge CLK160M);
    bus.TRG_IN = 1'b0;
    repeat (20) @(negedge CLK160M);
`endif
    repeat (10) @(negedge CLK160M);
    chk("pending_events", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", nt, nf);
    $finish;
  end
endmodule

// File: doc/ptmch_trig_gen.md
# ptmch_trig_gen

Parametrised, SPI-programmable multi-channel trigger pulse generator in the 160 MHz domain, successor to the fixed 5-output pulse block inside `ptmch_top`. A host writes per-channel delay, width, period and repeat count over a write-only SPI link, then fires any subset of channels with one command. Each channel emits a programmable pulse train on its `TRG_PLS` bit.

## Interface
- `CH_N`, 5: number of trigger channels (1–16).
- `CNT_W`, 16: width of delay/width/period/count registers (8–24).
- `CLK160M`  in  1  system clock, 160 MHz.
- `RESET_N`  in  1  asynchronous active-low reset; release is synchronised to `CLK160M`.
- `SPI_CS`  in  1  chip select, active-low, asynchronous to `CLK160M`.
- `SPI_CLK`  in  1  SPI clock, mode 0, ≤ 20 MHz, asynchronous.
- `SPI_MOSI`  in  1  serial data, MSB first.
- `TRG_IN`  in  1  external trigger (present only with `PTMCH_EXT_TRG_EN`).
- `TRG_PLS`  out  CH_N  registered trigger outputs, active-high.

## Operation
- SPI inputs pass through 2-FF synchronisers. Bits are captured on the synchronised `SPI_CLK` rising edge while `SPI_CS`=0.
- Frame: 32 bits. [31:28] opcode, [27:24] channel, [23:0] value (low `CNT_W` bits used). Frame commits on `SPI_CS` deassertion only if exactly 32 bits were received. Otherwise it is discarded.
- Opcodes:
  - 0x1 DELAY[ch] (cycles from fire to first pulse).
  - 0x2 WIDTH[ch] (high cycles per pulse).
  - 0x3 PERIOD[ch] (rising-edge spacing).
  - 0x4 COUNT[ch] (pulses per train).
  - 0x5 FIRE: value[CH_N-1:0] is the channel mask; the channel field is ignored.
  - 0x6 ABORT: value[CH_N-1:0] is the channel mask.
  - Other opcodes are ignored.
- Register writes with channel ≥ `CH_N` are ignored. Registers reset to 0.
- Per-channel FSM states: IDLE, DELAY, HIGH, LOW.
  - IDLE→DELAY on fire. The delay counter loads DELAY.
  - DELAY→HIGH when the counter reaches 0.
  - HIGH holds for WIDTH cycles, then LOW if pulses remain, else IDLE.
  - LOW holds for PERIOD−WIDTH cycles, then HIGH.
- Register values are snapshotted at fire. Writes made during a train take effect on the next fire.
- Arithmetic, all unsigned `CNT_W`:
  - COUNT=0 is treated as 1.
  - Effective period = max(PERIOD, WIDTH+1).
  - WIDTH=0: the train runs its timing with no high output, then returns to IDLE.
- FIRE to a non-IDLE channel is ignored for that channel. Other channels in the mask still fire.
- ABORT forces IDLE and `TRG_PLS`[ch]=0 on the next cycle. ABORT to an IDLE channel has no effect.
- FIRE and ABORT cannot collide, because only one frame commits per cycle.
- Reset at any point: all FSMs go to IDLE, `TRG_PLS`=0, registers cleared, the partial frame is dropped.

## Timing
- Commit strobe at cycle T occurs 3 `CLK160M` cycles after the raw `SPI_CS` rising edge (sync plus edge detect).
- For FIRE committed at T, with D=DELAY, W=WIDTH, P=effective period:
  - `TRG_PLS`[ch] is high over cycles [T+2+D, T+1+D+W].
  - Pulse k (0-based) starts at T+2+D+k·P.
- Channels fired by the same FIRE frame are cycle-aligned.
- The channel is back in IDLE, and accepts FIRE, the cycle after its last HIGH ends.
- `TRG_PLS` is driven directly from flops, with no combinational path from inputs.

## Configuration
- `PTMCH_EXT_TRG_EN` defined:
  - Adds port `TRG_IN`, 2-FF synchronised with rising-edge detect.
  - Opcode 0x7 ARM writes an arm mask.
  - A `TRG_IN` rising edge at synchronised cycle T acts as FIRE of the arm mask at T, with identical timing.
  - The arm mask is cleared by reset only.
- Undefined: no `TRG_IN` port, opcode 0x7 is ignored, and no arm register exists.

## Test plan
- Reset mid-train (`RESET_N` low during HIGH) → `TRG_PLS`=0 immediately; after reset, FIRE ch0 with no writes → no pulse, FSM returns to IDLE.
- Program ch2 DELAY=10, WIDTH=4, COUNT=1, then FIRE mask 0x04 → `TRG_PLS`[2] high exactly over cycles T+12..T+15, all other bits 0.
- Program ch0/ch4 WIDTH=3, PERIOD=8, COUNT=3, DELAY=0, then FIRE 0x11 → both emit 3 aligned 3-cycle pulses starting T+2, T+10, T+18.
- 31-bit frame carrying FIRE 0x1F → no output change. 33-bit frame → also discarded. Write to channel 9 with `CH_N`=5 → no register change.
- Ch1 COUNT=100, PERIOD=2 (<WIDTH=5) → spacing 6 cycles. ABORT 0x02 mid-train → low the next cycle. Re-FIRE during the train → ignored.
- With `PTMCH_EXT_TRG_EN`: ARM 0x0A, DELAY=0, WIDTH=2, pulse `TRG_IN` → ch1 and ch3 high at synchronised-edge cycle +2 for 2 cycles.
